// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add or restoring-divide step per clock on operand magnitudes; sign fix-up at the end.
module muldiv_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall
);

    localparam logic [3:0] OpMult = 4'b1111;
    localparam logic [3:0] OpDiv  = 4'b1110;
    localparam logic [3:0] OpMfhi = 4'b0011;
    localparam logic [3:0] OpMflo = 4'b0100;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFin  = 2'd2;

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    logic [1:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
    logic               neg_q, neg_d;
    logic               sa_q, sa_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   remv;
    logic               accept;

    always_comb begin
        sign_a = (SIGNED != 0) && a[WIDTH-1];
        sign_b = (SIGNED != 0) && b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
        accept = start && !flush && (op == OpMult || op == OpDiv);
    end

    // Datapath steps; the multiplier and quotient share the low half of acc_q.
    always_comb begin
        mul_addend = acc_q[0] ? mag_a_q : {WIDTH{1'b0}};
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        div_shift  = {rem_q, acc_q[WIDTH-1]};
        div_ge     = div_shift >= {1'b0, mag_b_q};
        div_diff   = div_shift[WIDTH-1:0] - mag_b_q;
        prod       = neg_q ? -acc_q : acc_q;
        quot       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        remv       = sa_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    is_div_d = (op == OpDiv);
                    sa_d     = sign_a;
                    neg_d    = sign_a ^ sign_b;
                    mag_a_d  = mag_a;
                    mag_b_d  = mag_b;
                    cnt_d    = '0;
                    rem_d    = '0;
                    acc_d    = (op == OpDiv) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                    dz_d     = (op == OpDiv) && (b == '0);
                    // A zero divisor skips the iterations and reports from FIN.
                    state_d  = ((op == OpDiv) && (b == '0)) ? StFin : StRun;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (is_div_q) begin
                        rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
                if (!flush) begin
                    done_d = 1'b1;
                    dbz_d  = dz_q;
                    if (!dz_q) begin
                        if (is_div_q) begin
                            hi_d = remv;
                            lo_d = quot;
                        end else begin
                            {hi_d, lo_d} = prod;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        busy        = (state_q != StIdle);
        stall       = start && busy;
        done        = done_q;
        div_by_zero = dbz_q;
        hi          = hi_q;
        lo          = lo_q;
        case (op)
            OpMfhi:  rd_data = hi_q;
            OpMflo:  rd_data = lo_q;
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: signed and unsigned instances share stimulus and are
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;
    localparam logic [3:0] OP_MULT = 4'b1111;
    localparam logic [3:0] OP_DIV  = 4'b1110;
    localparam logic [3:0] OP_MFHI = 4'b0011;
    localparam logic [3:0] OP_MFLO = 4'b0100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   op = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         busy_s, done_s, dbz_s, stall_s;
    logic [W-1:0] hi_s, lo_s, rd_s;
    logic         busy_u, done_u, dbz_u, stall_u;
    logic [W-1:0] hi_u, lo_u, rd_u;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_hi_s = '0, exp_lo_s = '0, exp_hi_u = '0, exp_lo_u = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy_s), .done(done_s), .div_by_zero(dbz_s), .hi(hi_s), .lo(lo_s),
        .rd_data(rd_s), .stall(stall_s)
    );

    muldiv_unit #(.WIDTH(W), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy_u), .done(done_u), .div_by_zero(dbz_u), .hi(hi_u), .lo(lo_u),
        .rd_data(rd_u), .stall(stall_u)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    // Returns {hi, lo}: product, or {remainder, quotient} with C-style truncation.
    function automatic logic [63:0] model(input bit sgn, input logic [3:0] o,
                                          input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = sgn ? longint'($signed(x)) : longint'({32'b0, x});
        sy = sgn ? longint'($signed(y)) : longint'({32'b0, y});
        if (o == OP_MULT) begin
            p = sx * sy;
        end else begin
            q = sx / sy;
            r = sx % sy;
            p = {r[31:0], q[31:0]};
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hilo(input string tag);
        check({tag, "_hi_s"}, hi_s, exp_hi_s);
        check({tag, "_lo_s"}, lo_s, exp_lo_s);
        check({tag, "_hi_u"}, hi_u, exp_hi_u);
        check({tag, "_lo_u"}, lo_u, exp_lo_u);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int edges;
        int busy_cyc;
        bit dz;
        dz = (o == OP_DIV) && (y == 0);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 4'h0;
        edges = 1;
        busy_cyc = 0;
        while (done_s !== 1'b1 && edges < 100) begin
            busy_cyc += int'(busy_s === 1'b1);
            tick();
            edges++;
        end
        check("done_seen_s", done_s, 1);
        check("done_seen_u", done_u, 1);
        check("latency_edges", edges, dz ? 2 : W + 2);
        check("busy_cycles", busy_cyc, dz ? 1 : W + 1);
        check("busy_low_at_done", busy_s, 0);
        if (!dz) begin
            {exp_hi_s, exp_lo_s} = model(1'b1, o, x, y);
            {exp_hi_u, exp_lo_u} = model(1'b0, o, x, y);
        end
        check_hilo("result");
        check("dbz_s", dbz_s, dz);
        check("dbz_u", dbz_u, dz);
        tick();
        check("done_one_cycle", {done_s, done_u}, 0);
        check("dbz_held", dbz_s, dz);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] x, y;
        logic [3:0] o;

        #12;
        check("rst_busy", {busy_s, busy_u}, 0);
        check("rst_done", {done_s, done_u}, 0);
        check("rst_dbz", {dbz_s, dbz_u}, 0);
        check("rst_hilo", {hi_s, lo_s, hi_u, lo_u}, 0);

        // Start on the first edge after reset release.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(OP_MULT, 32'd7, 32'hFFFFFFFD);
        check("mult_7_m3_hi", hi_s, 32'hFFFFFFFF);
        check("mult_7_m3_lo", lo_s, 32'hFFFFFFEB);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        check("div_m7_2_lo", lo_s, 32'hFFFFFFFD);
        check("div_m7_2_hi", hi_s, 32'hFFFFFFFF);

        run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("umult_hi", hi_u, 32'hFFFFFFFE);
        check("umult_lo", lo_u, 32'h00000001);

        // 0x451 / 0x20 leaves hi=0x11, lo=0x22 before the divide by zero.
        run_op(OP_DIV, 32'h451, 32'h20);
        check("preset_hi", hi_s, 32'h11);
        check("preset_lo", lo_s, 32'h22);
        run_op(OP_DIV, 32'd5, 32'd0);
        check("dz_hi_kept", hi_s, 32'h11);
        check("dz_lo_kept", lo_s, 32'h22);
        run_op(OP_MULT, 32'd3, 32'd4);
        check("dbz_cleared", dbz_s, 0);

        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        check("min_div_m1_lo", lo_s, 32'h80000000);
        check("min_div_m1_hi", hi_s, 32'h0);

        for (int i = 0; i < 20; i++) begin
            o = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
            x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = $urandom_range(1, 15);
                2: y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            run_op(o, x, y);
        end

        // Requests while busy are stalled and ignored; reads see the old HI/LO.
        start = 1'b1; op = OP_MULT; a = 32'd1234; b = 32'hFFFFEC78;
        tick();
        op = 4'h0; start = 1'b0;
        tick();
        start = 1'b1; op = OP_MULT; a = 32'd99; b = 32'd99;
        #1;
        check("stall_mult_busy", stall_s, 1);
        tick();
        op = OP_MFLO;
        #1;
        check("stall_mflo_busy", stall_s, 1);
        check("rd_old_lo_s", rd_s, exp_lo_s);
        check("rd_old_lo_u", rd_u, exp_lo_u);
        op = OP_MFHI;
        #1;
        check("rd_old_hi_s", rd_s, exp_hi_s);
        op = OP_MFLO;
        n = 0;
        while (done_s !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("stall_op_done", done_s, 1);
        {exp_hi_s, exp_lo_s} = model(1'b1, OP_MULT, 32'd1234, 32'hFFFFEC78);
        {exp_hi_u, exp_lo_u} = model(1'b0, OP_MULT, 32'd1234, 32'hFFFFEC78);
        check_hilo("stall_result");
        check("rd_new_lo_s", rd_s, exp_lo_s);
        check("stall_idle", stall_s, 0);
        tick();
        check("mflo_idle_no_busy", busy_s, 0);
        start = 1'b0; op = 4'h0;
        tick();

        // Flush on the 10th RUN cycle.
        start = 1'b1; op = OP_MULT; a = 32'h12345; b = 32'h6789;
        tick();
        start = 1'b0; op = 4'h0;
        repeat (9) tick();
        check("busy_before_flush", busy_s, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {busy_s, busy_u}, 0);
        check("flush_done", {done_s, done_u}, 0);
        check_hilo("flush");
        n = 0;
        repeat (40) begin
            tick();
            n += int'(done_s === 1'b1);
        end
        check("flush_no_done", n, 0);
        start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0; op = 4'h0;
        check("start_flush_idle", busy_s, 0);
        tick();
        check("start_flush_idle2", {busy_s, done_s}, 0);

        // Short asynchronous reset mid-RUN.
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0; op = 4'h0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {busy_s, busy_u}, 0);
        check("arst_done", {done_s, done_u}, 0);
        check("arst_dbz", {dbz_s, dbz_u}, 0);
        check("arst_hilo", {hi_s, lo_s, hi_u, lo_u}, 0);
        #1;
        rst_n = 1'b1;
        exp_hi_s = '0; exp_lo_s = '0; exp_hi_u = '0; exp_lo_u = '0;
        n = 0;
        repeat (40) begin
            tick();
            n += int'(done_s === 1'b1);
        end
        check("arst_no_done", n, 0);
        check_hilo("arst_after");

        run_op(OP_MULT, 32'hFFFFFFF0, 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width and width of each of HI and LO (legal values are even and at least 4).
REQ-002 SHALL have parameter SIGNED, default 1, meaning 1 = two's-complement mult/div and 0 = unsigned mult/div.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request valid for op in the current cycle.
REQ-006 SHALL have port op, input, 4 bits, using ALU-control codes:
- 1111 mult
- 1110 div
- 0011 MFHI
- 0100 MFLO
REQ-007 SHALL have ports a and b, input, WIDTH bits: multiplicand/multiplier, or dividend/divisor.
REQ-008 SHALL have port flush, input, 1 bit: synchronous abort of an in-flight operation.
REQ-009 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO are updated or a divide-by-zero is reported.
REQ-011 SHALL have port div_by_zero, output, 1 bit: qualifies done and holds its value until the next done.
REQ-012 SHALL have ports hi and lo, output, WIDTH bits: registered result registers.
REQ-013 SHALL have port rd_data, output, WIDTH bits: combinational read, equal to hi when op=0011, lo when op=0100, else 0.
REQ-014 SHALL have port stall, output, 1 bit: combinational, equal to start AND busy.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and FIN.
REQ-016 SHALL accept a request only in IDLE, with start=1, op in {1111,1110} and flush=0.
- On the accept edge, capture operand magnitudes and operand signs (signs only when SIGNED=1), clear the iteration counter, and enter RUN with busy=1.
REQ-017 SHALL, in RUN, perform exactly one iteration per clock, WIDTH iterations in total:
- mult: shift-add on a 2*WIDTH-bit accumulator.
- div: restoring step on a WIDTH+1-bit partial remainder.
- After the WIDTH-th iteration edge, enter FIN.
REQ-018 SHALL, on the FIN edge, apply the sign fix-up and write the results, then return to IDLE with busy=0 and done=1 for exactly one cycle:
- mult: {hi,lo} = product.
- div: lo = quotient, truncated toward zero; hi = remainder, taking the sign of the dividend.
REQ-019 SHALL give a latency of WIDTH+2 edges from the accept edge to the edge that raises done; busy SHALL be high for exactly WIDTH+1 cycles.
REQ-020 SHALL handle div with b=0 as follows:
- Skip RUN and return to IDLE on the next edge.
- Assert done=1 and div_by_zero=1.
- Leave hi and lo unchanged.
REQ-021 SHALL clear div_by_zero on every other done.
REQ-022 SHALL, for signed div of the most-negative value by -1, produce lo = most-negative value and hi = 0, with no flag.
REQ-023 SHALL ignore start while busy; stall=1 in that cycle, and rd_data returns the old hi/lo value.
REQ-024 SHALL ignore start in IDLE for any op other than 1111/1110; no state change results.
REQ-025 SHALL, when flush=1 in RUN or FIN, enter IDLE on the next edge:
- busy=0, with no done pulse.
- hi and lo unchanged.
- flush takes priority over completion in the same cycle.
REQ-026 SHALL, when flush and start are both 1 in IDLE, ignore start.
REQ-027 SHALL make hi and lo change only on the FIN edge or on reset.

Reset
REQ-028 SHALL, on assertion of rst_n=0 (immediate and asynchronous), force:
- state=IDLE
- busy=0, done=0, div_by_zero=0
- hi=0, lo=0
- counter and datapath registers cleared
REQ-029 SHALL, on reset during RUN or FIN, abandon the operation; no done is produced after reset release.
REQ-030 SHALL treat a start on the first edge after reset release as a legal request.

Verification (WIDTH=32)
REQ-031 SHALL test a signed mult of 7 * 0xFFFFFFFD (-3): response hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly 34 edges after accept, busy high for 33 cycles.
REQ-032 SHALL test signed div of 0xFFFFFFF9 (-7) by 2: response lo=0xFFFFFFFD, hi=0xFFFFFFFF; with SIGNED=0, 0xFFFFFFFF * 0xFFFFFFFF SHALL give hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL test div of 5 by 0 with prior hi=0x11, lo=0x22: response done plus div_by_zero on the edge after accept, hi=0x11, lo=0x22 unchanged, and a following valid mult clears div_by_zero.
REQ-034 SHALL test start with op=0100 during busy: response stall=1 and rd_data = old lo; after done, op=0100 returns the new lo with stall=0.
REQ-035 SHALL test flush at the 10th RUN cycle: response busy=0 next cycle, no done, hi/lo unchanged; a simultaneous start+flush in IDLE SHALL leave busy=0.
REQ-036 SHALL test rst_n low for a fraction of a cycle mid-RUN: response outputs reach their reset values immediately, asynchronously, and no done follows.
